spu_cmd_sequencer: RTL and testbench
====================================

SPU_CMD_SEQUENCER -- requirements
Module: spu_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of assembled commands buffered (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles to wait for a datapath result (1..15).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-005 cmd_valid  in  1  host byte valid.
REQ-006 cmd_data  in  8  host command byte.
REQ-007 cmd_ready  out  1  sequencer accepts cmd_data this cycle.
REQ-008 issue_valid  out  1  operation presented to SPU datapath.
REQ-009 issue_op  out  4  opcode to datapath.
REQ-010 issue_a, issue_b  out  8 each  operands to datapath.
REQ-011 issue_ready  in  1  datapath accepts operation.
REQ-012 res_valid  in  1  datapath result strobe (single cycle).
REQ-013 res_data  in  8  datapath result.
REQ-014 out_valid  out  1  result available to host.
REQ-015 out_data  out  8  result to host.
REQ-016 out_ready  in  1  host accepts result.
REQ-017 busy  out  1  high when FIFO non-empty or issue FSM not IDLE.
REQ-018 err  out  1  sticky error flag.

Function
REQ-019 Byte transfer occurs when cmd_valid && cmd_ready; command = 3 bytes: OP (opcode in [3:0], [7:4] must be 0), A, B.
REQ-020 Assembler FSM states A_OP -> A_A -> A_B -> A_OP, advancing one state per accepted byte.
REQ-021 OP byte with [7:4] != 0: byte dropped, err set, assembler remains in A_OP.
REQ-022 cmd_ready SHALL be low only when assembler is in A_B and FIFO is full; high otherwise.
REQ-023 Accepted B byte pushes {op,A,B} into FIFO in the same edge; simultaneous push and pop leave occupancy unchanged.
REQ-024 Issue FSM states: IDLE, ISSUE, WAIT, OUT.
REQ-025 IDLE: if FIFO non-empty, pop head, latch into issue registers, go ISSUE; entry pushed at edge N is issued (issue_valid high) from cycle N+1 when IDLE and FIFO previously empty.
REQ-026 ISSUE: issue_valid high, issue_op/a/b stable until issue_ready; on handshake go WAIT, clear timeout counter.
REQ-027 WAIT: on res_valid latch res_data into out_data, go OUT; counter increments each cycle without res_valid.
REQ-028 WAIT timeout: counter reaching TIMEOUT without res_valid sets err, out_data=8'hFF, go OUT.
REQ-029 res_valid in any state other than WAIT SHALL be ignored.
REQ-030 OUT: out_valid high, out_data stable until out_ready; on handshake go IDLE (next pop no earlier than following cycle).
REQ-031 Strict in-order: results appear in command acceptance order; one operation outstanding at a time.
REQ-032 err clears only on rst.
REQ-033 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-034 On rst: assembler A_OP, issue FSM IDLE, FIFO empty, counter 0, err 0.
REQ-035 Outputs during/after rst: cmd_ready 1, issue_valid 0, issue_op/a/b 0, out_valid 0, out_data 0, busy 0, err 0.
REQ-036 rst mid-operation discards partial command, FIFO contents and outstanding operation; a res_valid arriving after rst is ignored.

Verification
REQ-037 Bytes 03,12,34 with issue_ready=1, res_valid+res_data=46 two cycles after issue -> issue_op=3,a=12h,b=34h; out_valid with out_data=46h; err=0.
REQ-038 Byte A5 as OP -> dropped, err=1, next bytes 01,02,03 still form a valid command issued as op=1,a=02,b=03.
REQ-039 issue_ready=0, send 5 commands (depth 4) -> 4 buffered plus 1 in issue regs; cmd_ready low at 6th command's B byte until a pop; all results emerge in order.
REQ-040 Command issued, res_valid never asserted -> after 15 WAIT cycles err=1, out_valid with out_data=FFh; next command proceeds normally.
REQ-041 rst asserted in WAIT, then res_valid pulsed -> out_valid stays 0, busy=0, cmd_ready=1.
REQ-042 out_ready held low 10 cycles in OUT -> out_valid and out_data stable, no new issue_valid until out_ready.

Source files
------------

// File: rtl/spu_cmd_sequencer.sv
// spu_cmd_sequencer: gathers 3-byte host commands (OP, A, B), buffers them
// in a small FIFO, and runs them one at a time through the SPU datapath.
// Results go back to the host strictly in the order the commands arrived.
module spu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       issue_valid,
  output logic [3:0] issue_op,
  output logic [7:0] issue_a,
  output logic [7:0] issue_b,
  input  logic       issue_ready,
  input  logic       res_valid,
  input  logic [7:0] res_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {A_OP, A_A, A_B} asm_state_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} iss_state_t;

  asm_state_t asm_state, asm_next;
  iss_state_t iss_state, iss_next;

  logic [3:0]       op_hold;
  logic [7:0]       a_hold;
  logic [19:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       wait_cnt;

  logic byte_fire, bad_op, push, pop;
  logic fifo_full, fifo_empty, timeout_hit;

  assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  // Only the B byte completes a command, so only it has to wait for FIFO room.
  assign cmd_ready   = !((asm_state == A_B) && fifo_full);
  assign byte_fire   = cmd_valid && cmd_ready;
  assign bad_op      = byte_fire && (asm_state == A_OP) && (cmd_data[7:4] != 4'h0);
  assign push        = byte_fire && (asm_state == A_B);
  assign pop         = (iss_state == IDLE) && !fifo_empty;
  // A result arriving in the last allowed cycle still wins over the timeout.
  assign timeout_hit = (iss_state == WAIT) && !res_valid && (wait_cnt == 4'(TIMEOUT - 1));

  assign issue_valid = (iss_state == ISSUE);
  assign out_valid   = (iss_state == OUT);
  assign busy        = !fifo_empty || (iss_state != IDLE);

  // State registers for both FSMs.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state <= A_OP;
      iss_state <= IDLE;
    end else begin
      asm_state <= asm_next;
      iss_state <= iss_next;
    end
  end

  // Assembler next state: one step per accepted byte; a malformed OP byte is dropped.
  always_comb begin
    asm_next = asm_state;
    if (byte_fire) begin
      case (asm_state)
        A_OP:    if (!bad_op) asm_next = A_A;
        A_A:     asm_next = A_B;
        A_B:     asm_next = A_OP;
        default: asm_next = A_OP;
      endcase
    end
  end

  // Issue next state: pop, hand to datapath, wait for result, hand to host.
  always_comb begin
    iss_next = iss_state;
    case (iss_state)
      IDLE:    if (!fifo_empty) iss_next = ISSUE;
      ISSUE:   if (issue_ready) iss_next = WAIT;
      WAIT:    if (res_valid || timeout_hit) iss_next = OUT;
      OUT:     if (out_ready) iss_next = IDLE;
      default: iss_next = IDLE;
    endcase
  end

  // Hold the OP and A bytes until the B byte completes the command.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_hold <= '0;
      a_hold  <= '0;
    end else if (byte_fire) begin
      if ((asm_state == A_OP) && !bad_op) op_hold <= cmd_data[3:0];
      if (asm_state == A_A) a_hold <= cmd_data;
    end
  end

  // FIFO storage; the accepted B byte goes straight in alongside the held bytes.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {op_hold, a_hold, cmd_data};
  end

  // FIFO pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue registers stay fixed from the pop until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_op <= '0;
      issue_a  <= '0;
      issue_b  <= '0;
    end else if (pop) begin
      {issue_op, issue_a, issue_b} <= fifo_mem[rd_ptr];
    end
  end

  // Count WAIT cycles that pass without a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((iss_state == ISSUE) && issue_ready) begin
      wait_cnt <= '0;
    end else if ((iss_state == WAIT) && !res_valid) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Capture the datapath result, or the FFh marker when the datapath never answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (iss_state == WAIT) begin
      if (res_valid)        out_data <= res_data;
      else if (timeout_hit) out_data <= 8'hFF;
    end
  end

  // Sticky error: malformed OP byte or datapath timeout; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bad_op || timeout_hit) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spu_cmd_sequencer.sv
// Testbench for spu_cmd_sequencer: a hand-computed vector table, directed
// corner sequences, and randomized traffic checked against a queue-based model.
module tb_spu_cmd_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 15;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_data;
  logic       issue_valid, issue_ready;
  logic [3:0] issue_op;
  logic [7:0] issue_a, issue_b;
  logic       res_valid;
  logic [7:0] res_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       busy, err;

  spu_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
    .issue_ready(issue_ready),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct packed {
    logic       cv;
    logic [7:0] cd;
    logic       ir;
    logic       rv;
    logic [7:0] rd;
    logic       ordy;
    logic       e_cr;
    logic       e_iv;
    logic [3:0] e_op;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: host byte stream, accepted commands, expected results.
  logic [7:0]  byte_q[$];
  logic [19:0] cmd_q[$];
  logic [7:0]  exp_out_q[$];
  logic        exp_err;
  int          phase;
  logic [3:0]  m_op;
  logic [7:0]  m_a;
  logic        pending;
  int          wait_idx;
  int          resp_delay;
  logic [7:0]  resp_data;
  int          host_pct, ir_pct, or_pct, noise_pct, delay_min, delay_max;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_output(name, {7'd0, act}, {7'd0, exp});
  endtask

  function automatic vec_t mk(input logic cv, input logic [7:0] cd, input logic ir, input logic rv,
                              input logic [7:0] rd, input logic ordy, input logic e_cr, input logic e_iv,
                              input logic [3:0] e_op, input logic [7:0] e_a, input logic [7:0] e_b,
                              input logic e_ov, input logic [7:0] e_od, input logic e_busy,
                              input logic e_err);
    vec_t v;
    v.cv = cv; v.cd = cd; v.ir = ir; v.rv = rv; v.rd = rd; v.ordy = ordy;
    v.e_cr = e_cr; v.e_iv = e_iv; v.e_op = e_op; v.e_a = e_a; v.e_b = e_b;
    v.e_ov = e_ov; v.e_od = e_od; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check_bit({tag, "_issue_valid"}, issue_valid, 1'b0);
    check_output({tag, "_issue_op"}, {4'd0, issue_op}, 8'h00);
    check_output({tag, "_issue_a"}, issue_a, 8'h00);
    check_output({tag, "_issue_b"}, issue_b, 8'h00);
    check_bit({tag, "_out_valid"}, out_valid, 1'b0);
    check_output({tag, "_out_data"}, out_data, 8'h00);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
  endtask

  task automatic model_clear();
    byte_q.delete();
    cmd_q.delete();
    exp_out_q.delete();
    exp_err  = 1'b0;
    phase    = 0;
    pending  = 1'b0;
    wait_idx = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_data = 8'h00; issue_ready = 1'b0;
    res_valid = 1'b0; res_data = 8'h00; out_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Command parsing in terms of the byte protocol: OP (upper nibble zero), A, B.
  task automatic model_byte(input logic [7:0] b);
    case (phase)
      0: begin
        if (b[7:4] != 4'h0) exp_err = 1'b1;
        else begin m_op = b[3:0]; phase = 1; end
      end
      1: begin m_a = b; phase = 2; end
      default: begin cmd_q.push_back({m_op, m_a, b}); phase = 0; end
    endcase
  endtask

  task automatic queue_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    byte_q.push_back({4'h0, op});
    byte_q.push_back(a);
    byte_q.push_back(b);
  endtask

  task automatic queue_random_cmds(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) byte_q.push_back({4'($urandom_range(15, 1)), 4'($urandom)});
      queue_cmd(4'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  // One clock of the randomized environment: host, datapath and consumer all act,
  // the model predicts what the coming edge does, then the edge happens.
  task automatic tick();
    logic        cmd_fire, issue_fire, out_fire;
    logic [19:0] exp_cmd;
    check_bit("err_track", err, exp_err);
    if (pending) check_bit("one_outstanding", issue_valid, 1'b0);

    cmd_valid   = (byte_q.size() > 0) && ($urandom_range(99) < host_pct);
    cmd_data    = cmd_valid ? byte_q[0] : 8'($urandom);
    issue_ready = ($urandom_range(99) < ir_pct);
    out_ready   = ($urandom_range(99) < or_pct);
    res_valid   = 1'b0;
    res_data    = 8'($urandom);
    if (pending) begin
      if (wait_idx == resp_delay) begin
        res_valid = 1'b1;
        res_data  = resp_data;
        exp_out_q.push_back(resp_data);
        pending = 1'b0;
      end else if (wait_idx == TIMEOUT - 1) begin
        exp_out_q.push_back(8'hFF);
        exp_err = 1'b1;
        pending = 1'b0;
      end else begin
        wait_idx++;
      end
    end else if ($urandom_range(99) < noise_pct) begin
      res_valid = 1'b1;
    end

    cmd_fire   = cmd_valid && cmd_ready;
    issue_fire = issue_valid && issue_ready;
    out_fire   = out_valid && out_ready;

    if (cmd_fire) model_byte(byte_q.pop_front());
    if (issue_fire) begin
      check_bit("issue_has_cmd", cmd_q.size() > 0, 1'b1);
      if (cmd_q.size() > 0) begin
        exp_cmd = cmd_q.pop_front();
        check_output("issue_op", {4'd0, issue_op}, {4'd0, exp_cmd[19:16]});
        check_output("issue_a", issue_a, exp_cmd[15:8]);
        check_output("issue_b", issue_b, exp_cmd[7:0]);
      end
      pending    = 1'b1;
      wait_idx   = 0;
      resp_delay = int'($urandom_range(delay_max, delay_min));
      resp_data  = 8'($urandom);
    end
    if (out_fire) begin
      check_bit("out_has_result", exp_out_q.size() > 0, 1'b1);
      if (exp_out_q.size() > 0) check_output("out_data", out_data, exp_out_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic work_left();
    return (byte_q.size() != 0) || (cmd_q.size() != 0) || (exp_out_q.size() != 0) ||
           pending || busy;
  endfunction

  task automatic run_drain(input int budget, input string name);
    int n = 0;
    while (work_left() && n < budget) begin
      tick();
      n++;
    end
    check_bit({name, "_drained"}, !work_left(), 1'b1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    cmd_valid = v.cv; cmd_data = v.cd; issue_ready = v.ir;
    res_valid = v.rv; res_data = v.rd; out_ready = v.ordy;
    @(posedge clk); #1;
  endtask

  initial begin
    int         n;
    logic [7:0] held;

    rst = 1'b1;
    host_pct = 100; ir_pct = 100; or_pct = 100; noise_pct = 0; delay_min = 1; delay_max = 1;
    do_reset();

    // Basic command, then a malformed OP byte followed by a valid command.
    vecs.push_back(mk(H, 8'h03, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, L));
    vecs.push_back(mk(H, 8'h12, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, L));
    vecs.push_back(mk(H, 8'h34, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, H, L));
    vecs.push_back(mk(L, 8'h00, H, L, 8'h00, L,  H, H, 4'h3, 8'h12, 8'h34, L, 8'h00, H, L));
    vecs.push_back(mk(L, 8'h00, H, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, H, L));
    vecs.push_back(mk(L, 8'h00, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, H, L));
    vecs.push_back(mk(L, 8'h00, L, H, 8'h46, L,  H, L, 4'h0, 8'h00, 8'h00, H, 8'h46, H, L));
    vecs.push_back(mk(L, 8'h00, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, H, 8'h46, H, L));
    vecs.push_back(mk(L, 8'h00, L, L, 8'h00, H,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, L));
    vecs.push_back(mk(H, 8'hA5, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, H));
    vecs.push_back(mk(H, 8'h01, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, H));
    vecs.push_back(mk(H, 8'h02, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, H));
    vecs.push_back(mk(H, 8'h03, L, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, H, H));
    vecs.push_back(mk(L, 8'h00, L, L, 8'h00, L,  H, H, 4'h1, 8'h02, 8'h03, L, 8'h00, H, H));
    vecs.push_back(mk(L, 8'h00, L, L, 8'h00, L,  H, H, 4'h1, 8'h02, 8'h03, L, 8'h00, H, H));
    vecs.push_back(mk(L, 8'h00, H, L, 8'h00, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, H, H));
    vecs.push_back(mk(L, 8'h00, L, H, 8'h77, L,  H, L, 4'h0, 8'h00, 8'h00, H, 8'h77, H, H));
    vecs.push_back(mk(L, 8'h00, L, L, 8'h00, H,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, H));
    vecs.push_back(mk(L, 8'h00, L, H, 8'h55, L,  H, L, 4'h0, 8'h00, 8'h00, L, 8'h00, L, H));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_bit($sformatf("v%0d_cmd_ready", i), cmd_ready, vecs[i].e_cr);
      check_bit($sformatf("v%0d_issue_valid", i), issue_valid, vecs[i].e_iv);
      check_bit($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check_bit($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      check_bit($sformatf("v%0d_err", i), err, vecs[i].e_err);
      if (vecs[i].e_iv) begin
        check_output($sformatf("v%0d_issue_op", i), {4'd0, issue_op}, {4'd0, vecs[i].e_op});
        check_output($sformatf("v%0d_issue_a", i), issue_a, vecs[i].e_a);
        check_output($sformatf("v%0d_issue_b", i), issue_b, vecs[i].e_b);
      end
      if (vecs[i].e_ov) check_output($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
    end

    // Backpressure: datapath stalled, six commands offered against a depth-4 FIFO.
    do_reset();
    host_pct = 100; ir_pct = 0; or_pct = 100; noise_pct = 0; delay_min = 1; delay_max = 3;
    for (int i = 0; i < 6; i++) queue_cmd(4'(i + 1), 8'(8'h10 + i), 8'(8'h20 + i));
    n = 0;
    while (byte_q.size() > 1 && n < 40) begin tick(); n++; end
    check_output("bp_bytes_left", 8'(byte_q.size()), 8'd1);
    check_bit("bp_cmd_ready_low", cmd_ready, 1'b0);
    check_bit("bp_issue_valid", issue_valid, 1'b1);
    check_output("bp_issue_op", {4'd0, issue_op}, 8'h01);
    repeat (3) tick();
    check_bit("bp_cmd_ready_still_low", cmd_ready, 1'b0);
    check_output("bp_bytes_still_left", 8'(byte_q.size()), 8'd1);
    ir_pct = 100;
    run_drain(400, "bp");

    // Datapath never answers: FFh result and err, then a normal command follows.
    delay_min = 99; delay_max = 99;
    queue_cmd(4'h9, 8'hAA, 8'hBB);
    run_drain(100, "timeout");
    check_bit("timeout_err", err, 1'b1);
    delay_min = 2; delay_max = 2;
    queue_cmd(4'h4, 8'h5C, 8'h6D);
    run_drain(100, "after_timeout");

    // Host refuses the result for 10 cycles while another command waits.
    do_reset();
    or_pct = 0; noise_pct = 30; delay_min = 1; delay_max = 1;
    queue_cmd(4'h2, 8'h11, 8'h22);
    queue_cmd(4'h7, 8'h33, 8'h44);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check_bit("hold_out_valid_seen", out_valid, 1'b1);
    held = (exp_out_q.size() > 0) ? exp_out_q[0] : 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_bit($sformatf("hold%0d_out_valid", i), out_valid, 1'b1);
      check_output($sformatf("hold%0d_out_data", i), out_data, held);
      check_bit($sformatf("hold%0d_no_issue", i), issue_valid, 1'b0);
    end
    or_pct = 100;
    run_drain(100, "hold");

    // Reset during WAIT, then a late result strobe must be ignored.
    noise_pct = 0; delay_min = 99; delay_max = 99;
    queue_cmd(4'h5, 8'h66, 8'h77);
    n = 0;
    while (!(pending && wait_idx >= 3) && n < 40) begin tick(); n++; end
    check_bit("wait_reached", pending, 1'b1);
    do_reset();
    res_valid = 1'b1; res_data = 8'h3C;
    @(posedge clk); #1;
    res_valid = 1'b0;
    check_bit("late_res_out_valid", out_valid, 1'b0);
    check_bit("late_res_busy", busy, 1'b0);
    check_bit("late_res_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    check_bit("late_res_out_valid_2", out_valid, 1'b0);
    check_bit("late_res_busy_2", busy, 1'b0);

    // Randomized traffic, including malformed bytes, timeouts and stray strobes.
    do_reset();
    host_pct = 70; ir_pct = 60; or_pct = 60; noise_pct = 20; delay_min = 0; delay_max = 17;
    queue_random_cmds(40);
    run_drain(3000, "rand_a");
    do_reset();
    host_pct = 100; ir_pct = 30; or_pct = 40; noise_pct = 10; delay_min = 0; delay_max = 5;
    queue_random_cmds(30);
    run_drain(3000, "rand_b");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
